// File: rtl/fp_pkg.sv
// Shared types and rounding decision for the FP divide/sqrt datapath.
package fp_pkg;

    typedef enum logic [1:0] {
        RNE = 2'd0,
        RTZ = 2'd1,
        RUP = 2'd2,
        RDN = 2'd3
    } rmode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } mdiv_state_t;

    // Directed modes round away from zero only when that moves toward their infinity.
    function automatic logic round_up(input rmode_t rmode, input logic sign,
                                      input logic lsb, input logic guard, input logic sticky);
        logic up;
        case (rmode)
            RNE:     up = guard & (sticky | lsb);
            RTZ:     up = 1'b0;
            RUP:     up = ~sign & (guard | sticky);
            RDN:     up = sign & (guard | sticky);
            default: up = 1'b0;
        endcase
        return up;
    endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational normaliser and rounder for a WIDTH+3 bit quotient/root with
// one integer bit; shared between the divider and the future sqrt unit.
module fp_round
    import fp_pkg::*;
#(
    parameter int WIDTH = 23
) (
    input  logic [WIDTH+2:0] quo,
    input  logic             rem_nz,
    input  rmode_t           rmode,
    input  logic             sign,
    output logic [WIDTH-1:0] frac_out,
    output logic             dec,
    output logic             inc,
    output logic             inexact
);

    logic [WIDTH-1:0] frac;
    logic             guard;
    logic             sticky;
    logic             up;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        frac     = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        dec      = 1'b0;
        up       = 1'b0;
        inc      = 1'b0;
        frac_out = '0;
        inexact  = 1'b0;

        if (quo[WIDTH+2]) begin
            frac   = quo[WIDTH+1:2];
            guard  = quo[1];
            sticky = quo[0] | rem_nz;
        end else begin
            frac   = quo[WIDTH:1];
            guard  = quo[0];
            sticky = rem_nz;
            dec    = 1'b1;
        end

        up                = round_up(rmode, sign, frac[0], guard, sticky);
        {inc, frac_out}   = {1'b0, frac} + {{WIDTH{1'b0}}, up};
        inexact           = guard | sticky;
    end

endmodule

// File: rtl/mdiv_seq.sv
// Sequential radix-2 restoring mantissa divider with valid/ready handshakes;
// one quotient bit per cycle, then normalise and round into registered outputs.
module mdiv_seq
    import fp_pkg::*;
#(
    parameter int WIDTH = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] m1,
    input  logic [WIDTH-1:0] m2,
    input  logic [1:0]       rmode,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] m3,
    output logic             decrement_exponent,
    output logic             increment_exponent,
    output logic             inexact
);

    localparam int Q  = WIDTH + 3;
    localparam int CW = $clog2(Q);

    mdiv_state_t      state;
    logic [WIDTH:0]   divisor;
    logic [WIDTH+1:0] rem;
    logic [WIDTH+2:0] quo;
    logic [CW-1:0]    count;
    rmode_t           rmode_q;
    logic             sign_q;

    // rem < 2*divisor always holds, so the doubled remainder fits in WIDTH+2 bits.
    logic             ge;
    logic [WIDTH+1:0] rem_sel;

    logic [WIDTH-1:0] r_frac;
    logic             r_dec;
    logic             r_inc;
    logic             r_inexact;

    assign in_ready = (state == IDLE);
    assign ge       = (rem >= {1'b0, divisor});
    assign rem_sel  = ge ? (rem - {1'b0, divisor}) : rem;

    fp_round #(.WIDTH(WIDTH)) u_round (
        .quo      (quo),
        .rem_nz   (rem != '0),
        .rmode    (rmode_q),
        .sign     (sign_q),
        .frac_out (r_frac),
        .dec      (r_dec),
        .inc      (r_inc),
        .inexact  (r_inexact)
    );

    // NOTE: only control and visible outputs are reset; the datapath is always
    // reloaded on accept, so clearing it would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            out_valid          <= 1'b0;
            m3                 <= '0;
            decrement_exponent <= 1'b0;
            increment_exponent <= 1'b0;
            inexact            <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        divisor <= {1'b1, m2};
                        rem     <= {1'b0, 1'b1, m1};
                        quo     <= '0;
                        count   <= '0;
                        rmode_q <= rmode_t'(rmode);
                        sign_q  <= sign;
                        state   <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem   <= rem_sel << 1;
                    quo   <= {quo[WIDTH+1:0], ge};
                    count <= count + 1'b1;
                    if (count == CW'(Q - 1)) state <= ROUND;
                end
                ROUND: begin
                    m3                 <= r_frac;
                    decrement_exponent <= r_dec;
                    increment_exponent <= r_inc;
                    inexact            <= r_inexact;
                    out_valid          <= 1'b1;
                    state              <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
